// File: rtl/psum_sext_accumulator.sv
// rtl/psum_sext_accumulator.sv - sign-extending group accumulator for narrow partial sums
// Sums NUM_ACC signed beats at O_SUM_BW with saturation, then presents one result over valid/ready.
module psum_sext_accumulator #(
   parameter int I_SUM_BW = 16,
   parameter int O_SUM_BW = 21,
   parameter int NUM_ACC  = 9,
   parameter int CNT_BW   = 4
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                i_clear,
   input  logic                s_valid,
   output logic                s_ready,
   input  logic [I_SUM_BW-1:0] i_psum,
   output logic                m_valid,
   input  logic                m_ready,
   output logic [O_SUM_BW-1:0] o_sum,
   output logic                o_sat
);

   typedef enum logic {ST_ACC, ST_HOLD} state_t;

   localparam logic [CNT_BW-1:0]   LAST_CNT = CNT_BW'(NUM_ACC - 1);
   localparam logic [O_SUM_BW-1:0] SUM_MAX  = {1'b0, {(O_SUM_BW-1){1'b1}}};
   localparam logic [O_SUM_BW-1:0] SUM_MIN  = {1'b1, {(O_SUM_BW-1){1'b0}}};

   state_t              r_state;
   state_t              w_state_nxt;
   logic [CNT_BW-1:0]   r_cnt;
   logic [O_SUM_BW-1:0] r_acc;
   logic [O_SUM_BW-1:0] r_sum;
   logic                r_grp_sat;
   logic                r_sat;

   logic                w_beat;
   logic                w_last;
   logic [O_SUM_BW-1:0] w_sext;
   logic [O_SUM_BW:0]   w_sum;
   logic [O_SUM_BW-1:0] w_acc_nxt;
   logic                w_sat_nxt;

   assign w_sext = {{(O_SUM_BW-I_SUM_BW){i_psum[I_SUM_BW-1]}}, i_psum};
   assign w_beat = s_valid && (r_state == ST_ACC);
   assign w_last = (r_cnt == LAST_CNT);
   // One guard bit: overflow shows up as the top two bits disagreeing.
   assign w_sum  = {r_acc[O_SUM_BW-1], r_acc} + {w_sext[O_SUM_BW-1], w_sext};

   always_comb begin
      w_acc_nxt = w_sum[O_SUM_BW-1:0];
      w_sat_nxt = r_grp_sat;
      if (r_cnt == '0) begin
         w_acc_nxt = w_sext;
         w_sat_nxt = 1'b0;
      end else if (w_sum[O_SUM_BW] != w_sum[O_SUM_BW-1]) begin
         w_acc_nxt = w_sum[O_SUM_BW] ? SUM_MIN : SUM_MAX;
         w_sat_nxt = 1'b1;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_ACC:  if (w_beat && w_last) w_state_nxt = ST_HOLD;
         ST_HOLD: if (m_ready)          w_state_nxt = ST_ACC;
         default:                       w_state_nxt = ST_ACC;
      endcase
      if (i_clear) w_state_nxt = ST_ACC;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= ST_ACC;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_cnt     <= '0;
         r_acc     <= '0;
         r_sum     <= '0;
         r_grp_sat <= 1'b0;
         r_sat     <= 1'b0;
      end else if (i_clear) begin
         r_cnt     <= '0;
         r_acc     <= '0;
         r_grp_sat <= 1'b0;
         r_sat     <= 1'b0;
      end else if (w_beat) begin
         r_acc     <= w_acc_nxt;
         r_grp_sat <= w_sat_nxt;
         if (w_last) begin
            r_cnt <= '0;
            r_sum <= w_acc_nxt;
            r_sat <= w_sat_nxt;
         end else begin
            r_cnt <= r_cnt + CNT_BW'(1);
         end
      end
   end

   assign s_ready = (r_state == ST_ACC);
   assign m_valid = (r_state == ST_HOLD);
   assign o_sum   = r_sum;
   assign o_sat   = r_sat;

endmodule

// File: tb/tb_psum_sext_accumulator.sv
// tb/tb_psum_sext_accumulator.sv - directed bench for psum_sext_accumulator
// Default, 18-bit-output and single-beat-group instances share one stimulus stream.
module tb_psum_sext_accumulator;

   logic        clk;
   logic        reset_n;
   logic        i_clear;
   logic        s_valid;
   logic [15:0] i_psum;
   logic        m_ready;

   logic        a_ready, a_valid, a_sat;
   logic [20:0] a_sum;
   logic        b_ready, b_valid, b_sat;
   logic [17:0] b_sum;
   logic        c_ready, c_valid, c_sat;
   logic [20:0] c_sum;

   int n_checks = 0;
   int n_errors = 0;

   psum_sext_accumulator u_dut_a (
      .clk(clk), .reset_n(reset_n), .i_clear(i_clear), .s_valid(s_valid), .s_ready(a_ready),
      .i_psum(i_psum), .m_valid(a_valid), .m_ready(m_ready), .o_sum(a_sum), .o_sat(a_sat)
   );

   psum_sext_accumulator #(.O_SUM_BW(18)) u_dut_b (
      .clk(clk), .reset_n(reset_n), .i_clear(i_clear), .s_valid(s_valid), .s_ready(b_ready),
      .i_psum(i_psum), .m_valid(b_valid), .m_ready(m_ready), .o_sum(b_sum), .o_sat(b_sat)
   );

   psum_sext_accumulator #(.NUM_ACC(1), .CNT_BW(1)) u_dut_c (
      .clk(clk), .reset_n(reset_n), .i_clear(i_clear), .s_valid(s_valid), .s_ready(c_ready),
      .i_psum(i_psum), .m_valid(c_valid), .m_ready(m_ready), .o_sum(c_sum), .o_sat(c_sat)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input longint obs, input longint exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic beat(input logic signed [15:0] v);
      s_valid = 1'b1;
      i_psum  = v;
      @(posedge clk);
      #1;
      s_valid = 1'b0;
   endtask

   task automatic group9(input logic signed [15:0] v);
      for (int i = 0; i < 9; i++) beat(v);
   endtask

   task automatic ack_a(input string tag);
      @(posedge clk);
      #1;
      chk({tag, "_mvalid"}, a_valid, 0);
      chk({tag, "_sready"}, a_ready, 1);
   endtask

   task automatic do_reset();
      #2 reset_n = 1'b0;
      #3 reset_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic signed [15:0] mixed [9];
      mixed = '{16'sd100, -16'sd300, 16'sd5, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0};
      reset_n = 1'b0;
      i_clear = 1'b0;
      s_valid = 1'b0;
      i_psum  = '0;
      m_ready = 1'b1;
      #12;
      chk("rst_mvalid", a_valid, 0);
      chk("rst_sum", $signed(a_sum), 0);
      chk("rst_sat", a_sat, 0);
      #10 reset_n = 1'b1;
      @(posedge clk);
      #1;
      chk("rst_sready", a_ready, 1);

      group9(16'sd32767);
      chk("pmax_valid", a_valid, 1);
      chk("pmax_sum", $signed(a_sum), 294903);
      chk("pmax_sat", a_sat, 0);
      chk("pmax_sready", a_ready, 0);
      chk("b_pmax_sum", $signed(b_sum), 131071);
      chk("b_pmax_sat", b_sat, 1);
      ack_a("pmax_ack");

      group9(16'sd1);
      chk("b_ones_sum", $signed(b_sum), 9);
      chk("b_ones_sat", b_sat, 0);
      chk("a_ones_sum", $signed(a_sum), 9);
      ack_a("ones_ack");

      group9(-16'sd32768);
      chk("nmax_sum", $signed(a_sum), -294912);
      chk("nmax_sat", a_sat, 0);
      chk("b_nmax_sum", $signed(b_sum), -131072);
      chk("b_nmax_sat", b_sat, 1);
      ack_a("nmax_ack");

      for (int i = 0; i < 9; i++) beat(mixed[i]);
      chk("mixed_valid", a_valid, 1);
      chk("mixed_sum", $signed(a_sum), -195);

      // Backpressure: result must hold and offered beats must not leak into the next group.
      m_ready = 1'b0;
      s_valid = 1'b1;
      i_psum  = 16'sd7;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         chk("bp_sum", $signed(a_sum), -195);
         chk("bp_valid", a_valid, 1);
         chk("bp_sready", a_ready, 0);
      end
      m_ready = 1'b1;
      @(posedge clk);
      #1;
      s_valid = 1'b0;
      chk("bp_rel_valid", a_valid, 0);
      chk("bp_rel_sready", a_ready, 1);
      group9(16'sd3);
      chk("bp_next_sum", $signed(a_sum), 27);
      ack_a("bp_next_ack");

      group9(16'sd4);
      m_ready = 1'b0;
      chk("hclr_pre_valid", a_valid, 1);
      i_clear = 1'b1;
      @(posedge clk);
      #1;
      i_clear = 1'b0;
      m_ready = 1'b1;
      chk("hclr_valid", a_valid, 0);
      chk("hclr_sready", a_ready, 1);

      for (int i = 0; i < 4; i++) beat(16'sd10);
      i_clear = 1'b1;
      s_valid = 1'b1;
      i_psum  = 16'sd50;
      @(posedge clk);
      #1;
      i_clear = 1'b0;
      s_valid = 1'b0;
      chk("abort_valid", a_valid, 0);
      chk("abort_sat", a_sat, 0);
      for (int i = 0; i < 8; i++) beat(16'sd1);
      chk("abort_no_early", a_valid, 0);
      beat(16'sd1);
      chk("abort_valid_out", a_valid, 1);
      chk("abort_sum", $signed(a_sum), 9);
      ack_a("abort_ack");

      for (int i = 0; i < 5; i++) beat(16'sd5);
      #3 reset_n = 1'b0;
      #1;
      chk("arst_valid", a_valid, 0);
      chk("arst_sum", $signed(a_sum), 0);
      chk("arst_sat", a_sat, 0);
      #3 reset_n = 1'b1;
      @(posedge clk);
      #1;
      group9(16'sd2);
      chk("arst_after_sum", $signed(a_sum), 18);
      ack_a("arst_ack");

      do_reset();
      beat(-16'sd5);
      chk("c_one_valid", c_valid, 1);
      chk("c_one_sum", $signed(c_sum), -5);
      chk("c_one_sat", c_sat, 0);
      @(posedge clk);
      #1;
      chk("c_ack_valid", c_valid, 0);
      beat(16'sd32767);
      chk("c_two_sum", $signed(c_sum), 32767);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/psum_sext_accumulator.md
Name: psum_sext_accumulator

Overview:
- Streaming reduction block that sits upstream of the partial-sum saturation stage, the opposite direction of that stage.
- Takes narrow signed partial sums from PE columns or readback buffers.
- Sign-extends each value to the wide accumulator width and accumulates a fixed group of NUM_ACC beats, for example the 9 taps of a 3x3 kernel.
- Emits one wide signed sum per group over a valid/ready handshake.

Parameters:
I_SUM_BW, 16, width of signed input partial sum.
O_SUM_BW, 21, width of signed accumulated output; must be greater than I_SUM_BW.
NUM_ACC, 9, beats per group; must be at least 1.
CNT_BW, 4, beat counter width; must satisfy 2^CNT_BW > NUM_ACC-1.

Ports:
clk  input  1  clock; all state updates on rising edge.
reset_n  input  1  asynchronous, active-low reset.
i_clear  input  1  synchronous abort of the current group.
s_valid  input  1  input beat valid.
s_ready  output  1  block can accept an input beat.
i_psum  input  I_SUM_BW  signed input partial sum.
m_valid  output  1  o_sum is valid.
m_ready  input  1  downstream accepts o_sum.
o_sum  output  O_SUM_BW  signed accumulated group result.
o_sat  output  1  the group saturated at least once; qualified by m_valid.

Behaviour:
- Reset (reset_n=0, asynchronous): state=ACC, cnt=0, acc=0, o_sum=0, o_sat=0, m_valid=0. s_ready=1 after reset release.
- States:
  - ACC: collecting beats. s_ready=1, m_valid=0.
  - HOLD: result presented. s_ready=0, m_valid=1.
- s_ready is a registered state decode; it has no combinational path from m_ready.
- Beat accepted when s_valid && s_ready.
- sext(x) = i_psum sign-extended to O_SUM_BW.
- First beat of a group (cnt==0): acc loads sext(i_psum); no add with the prior acc.
- Later beats:
  - sum = acc + sext(i_psum), computed at O_SUM_BW+1 bits.
  - Above +(2^(O_SUM_BW-1)-1): clip to that value and set group sat flag.
  - Below -2^(O_SUM_BW-1): clip to that value and set group sat flag.
  - Otherwise acc = sum.
- Group sat flag clears on the first beat of each group.
- Counter and group completion:
  - cnt increments per accepted beat.
  - On the accepted beat with cnt==NUM_ACC-1: o_sum <= final acc value including this beat; o_sat <= final flag; cnt <= 0; state <= HOLD.
  - NUM_ACC=1: every beat completes a group; o_sum = sext(i_psum).
- Latency: m_valid asserts the cycle after the last beat is accepted.
- HOLD:
  - o_sum and o_sat are stable while m_valid && !m_ready.
  - On m_valid && m_ready: state <= ACC, m_valid <= 0.
- Throughput: at most one group per NUM_ACC+1 cycles.
- s_valid with s_ready=0: the beat is not consumed, and upstream must hold it.
- i_clear=1: highest synchronous priority. Next edge gives state=ACC, cnt=0, acc=0, m_valid=0, o_sat=0. A pending HOLD result is discarded. Any beat presented that cycle is dropped.
- Reset mid-group or mid-HOLD: all partial state is lost with no output.
- Widths: no truncation on any path; i_psum enters only via sign extension.

Test Plan:
- Defaults, 9 beats of +32767, m_ready=1 → one cycle after beat 9: m_valid=1, o_sum=294903, o_sat=0. Then s_ready=1.
- Defaults, 9 beats of -32768 → o_sum=-294912, o_sat=0. Mixed beats +100, -300, +5 followed by six 0 beats → o_sum=-195.
- O_SUM_BW=18, 9 beats of +32767 → o_sum=131071, o_sat=1. The next group of 9 beats of +1 → o_sum=9, o_sat=0.
- Backpressure: group completes, m_ready=0 for 5 cycles → o_sum held constant, s_ready=0, s_valid beats not consumed. m_ready=1 → handshake, then s_ready=1 next cycle.
- Abort: 4 beats of +10, then i_clear pulse, then 9 beats of +1 → o_sum=9. No output is produced for the aborted group.
- Asynchronous reset asserted between clock edges after 5 beats → outputs are 0 immediately. After release, 9 beats of +2 → o_sum=18.
